// File: rtl/smiley_hit_edge_detector_if.sv
// smiley_hit_edge_detector_if: pixel-scan inputs and collision report outputs of the hit edge detector
interface smiley_hit_edge_detector_if;
  logic               startOfFrame;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               smileyDR;
  logic               obstacleDR;
  logic               collision;
  logic [3:0]         HitEdgeCode;
  logic [15:0]        hitPixelCount;
  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY, smileyDR, obstacleDR,
    input  collision, HitEdgeCode, hitPixelCount
  );
  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY, smileyDR, obstacleDR,
    output collision, HitEdgeCode, hitPixelCount
  );
endinterface

// File: rtl/smiley_hit_edge_detector.sv
// smiley_hit_edge_detector: accumulates smiley/obstacle overlap edge zones per frame, reports a delayed one-cycle collision
module smiley_hit_edge_detector #(
  parameter int OBJECT_WIDTH_X = 64,
  parameter int OBJECT_HIGHT_Y = 64,
  parameter int EDGE_MARGIN    = 16,
  parameter int MIN_HIT_PIXELS = 4,
  parameter int REPORT_DELAY   = 4
) (
  input logic clk,
  input logic resetN,
  smiley_hit_edge_detector_if.slave bus
);
  typedef enum logic [1:0] {IDLE_ST, COLLECT_ST, DELAY_ST, PULSE_ST} state_t;
  localparam logic signed [11:0] L_MARGIN = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] L_RIGHT  = 12'(OBJECT_WIDTH_X - EDGE_MARGIN);
  localparam logic signed [11:0] L_BOTTOM = 12'(OBJECT_HIGHT_Y - EDGE_MARGIN);
  localparam logic [15:0]        L_MIN    = 16'(MIN_HIT_PIXELS);
  localparam logic [7:0]         L_DELAY  = 8'(REPORT_DELAY - 1);
  state_t             r_state;
  logic [3:0]         r_edge_acc, r_snap_edge, r_hit_edge;
  logic [15:0]        r_pix_acc, r_snap_count, r_hit_count;
  logic [7:0]         r_delay;
  logic               r_collision;
  logic signed [11:0] w_off_x, w_off_y;
  logic               w_hit;
  logic [3:0]         w_edge;
  // signed offsets so pixels left of / above the box fall into the left/top zones
  assign w_off_x = $signed({1'b0, bus.pixelX}) - $signed({bus.topLeftX[10], bus.topLeftX});
  assign w_off_y = $signed({1'b0, bus.pixelY}) - $signed({bus.topLeftY[10], bus.topLeftY});
  assign w_hit   = bus.smileyDR & bus.obstacleDR;
  assign w_edge  = {w_off_x < L_MARGIN, w_off_y < L_MARGIN, w_off_x >= L_RIGHT, w_off_y >= L_BOTTOM};
  assign bus.collision     = r_collision;
  assign bus.HitEdgeCode   = r_hit_edge;
  assign bus.hitPixelCount = r_hit_count;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= IDLE_ST;
      r_edge_acc   <= '0;
      r_pix_acc    <= '0;
      r_snap_edge  <= '0;
      r_snap_count <= '0;
      r_delay      <= '0;
      r_collision  <= 1'b0;
      r_hit_edge   <= '0;
      r_hit_count  <= '0;
    end else if (bus.startOfFrame) begin
      r_edge_acc  <= '0;
      r_pix_acc   <= '0;
      r_collision <= 1'b0;
      if (r_state == IDLE_ST) begin
        r_state <= COLLECT_ST;
      end else begin
        r_snap_edge  <= r_edge_acc;
        r_snap_count <= r_pix_acc;
        if (r_pix_acc >= L_MIN && r_edge_acc != 4'd0) begin
          r_delay <= L_DELAY;
          r_state <= DELAY_ST;
        end else begin
          r_state <= COLLECT_ST;
        end
      end
    end else begin
      if (r_state != IDLE_ST && w_hit) begin
        r_edge_acc <= r_edge_acc | w_edge;
        r_pix_acc  <= r_pix_acc + {15'd0, r_pix_acc != 16'hFFFF};
      end
      // firing on the last count step makes the registered pulse land REPORT_DELAY cycles after SOF
      if (r_state == DELAY_ST) begin
        r_delay <= r_delay - 8'd1;
        if (r_delay == 8'd1) begin
          r_state     <= PULSE_ST;
          r_collision <= 1'b1;
          r_hit_edge  <= r_snap_edge;
          r_hit_count <= r_snap_count;
        end
      end else if (r_state == PULSE_ST) begin
        r_state     <= COLLECT_ST;
        r_collision <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_smiley_hit_edge_detector.sv
// tb_smiley_hit_edge_detector: directed frames with hand-computed edge codes, counts and pulse timing
module tb_smiley_hit_edge_detector;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  smiley_hit_edge_detector_if bus ();
  smiley_hit_edge_detector dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic drive(input int ox, input int oy, input logic s, input logic o);
    bus.pixelX     = 11'(100 + ox);
    bus.pixelY     = 11'(100 + oy);
    bus.smileyDR   = s;
    bus.obstacleDR = o;
  endtask
  task automatic px(input int ox, input int oy, input logic s, input logic o, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      drive(ox, oy, s, o);
    end
  endtask
  // SOF cycle always carries a top-left hit that must not be counted in any frame
  task automatic sof_only();
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    drive(0, 0, 1'b1, 1'b1);
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    drive(30, 30, 1'b0, 1'b0);
  endtask
  task automatic sof_check(input string tag, input logic pulse, input logic [3:0] code, input logic [15:0] cnt);
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    drive(0, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      drive(30, 30, 1'b0, 1'b0);
      chk($sformatf("%s collision@N+%0d", tag, k), 32'(bus.collision), 32'(pulse && k == 4));
    end
    chk({tag, " HitEdgeCode"}, 32'(bus.HitEdgeCode), 32'(code));
    chk({tag, " hitPixelCount"}, 32'(bus.hitPixelCount), 32'(cnt));
  endtask
  initial begin
    bus.startOfFrame = 1'b0;
    bus.topLeftX = 11'sd100;
    bus.topLeftY = 11'sd100;
    drive(30, 30, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset collision", 32'(bus.collision), 32'd0);
    chk("reset HitEdgeCode", 32'(bus.HitEdgeCode), 32'd0);
    chk("reset hitPixelCount", 32'(bus.hitPixelCount), 32'd0);
    resetN = 1'b1;
    px(2, 2, 1'b1, 1'b1, 5);
    sof_check("partial", 1'b0, 4'b0000, 16'd0);
    px(2, 30, 1'b1, 1'b1, 10);
    px(60, 60, 1'b1, 1'b0, 3);
    px(60, 60, 1'b0, 1'b1, 3);
    sof_check("left", 1'b1, 4'b1000, 16'd10);
    px(30, 5, 1'b1, 1'b1, 3);
    sof_check("debounce", 1'b0, 4'b1000, 16'd10);
    px(60, 60, 1'b1, 1'b1, 5);
    px(30, 1, 1'b1, 1'b1, 5);
    sof_check("corner", 1'b1, 4'b0111, 16'd10);
    px(30, 55, 1'b1, 1'b1, 20);
    sof_check("bottom", 1'b1, 4'b0001, 16'd20);
    px(30, 30, 1'b1, 1'b1, 6);
    sof_check("centre", 1'b0, 4'b0001, 16'd20);
    px(2, 30, 1'b1, 1'b1, 6);
    sof_only();
    sof_check("dropped", 1'b0, 4'b0001, 16'd20);
    px(2, 30, 1'b1, 1'b1, 6);
    sof_only();
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("midreset collision", 32'(bus.collision), 32'd0);
    chk("midreset HitEdgeCode", 32'(bus.HitEdgeCode), 32'd0);
    chk("midreset hitPixelCount", 32'(bus.hitPixelCount), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("postreset collision %0d", k), 32'(bus.collision), 32'd0);
    end
    px(60, 30, 1'b1, 1'b1, 4);
    sof_check("idle", 1'b0, 4'b0000, 16'd0);
    px(60, 30, 1'b1, 1'b1, 5);
    px(-5, 30, 1'b1, 1'b1, 2);
    sof_check("negoff", 1'b1, 4'b1010, 16'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/smiley_hit_edge_detector.md
Name: smiley_hit_edge_detector

Overview:
- Upstream stage of the smiley motion block. Produces that block's `collision` and `HitEdgeCode[3:0]` inputs.
- During each frame scan it watches pixels where the smiley drawing request overlaps an obstacle drawing request. It classifies each overlap pixel by its position inside the smiley bounding box (left/top/right/bottom zone) and accumulates the result.
- After `startOfFrame` it issues one delayed, single-cycle collision report with the accumulated edge code. The delay lands the pulse while the motion block is back in its moving state.

Parameters:
- OBJECT_WIDTH_X, 64, smiley bounding-box width in pixels
- OBJECT_HIGHT_Y, 64, smiley bounding-box height in pixels
- EDGE_MARGIN, 16, depth in pixels of each edge zone inside the box
- MIN_HIT_PIXELS, 4, minimum overlap pixels per frame needed to report (debounce)
- REPORT_DELAY, 4, clk cycles from the `startOfFrame` cycle to the collision pulse

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per frame
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- topLeftX  in  11 signed  smiley top-left X, from the motion block
- topLeftY  in  11 signed  smiley top-left Y, from the motion block
- smileyDR  in  1  smiley drawing request at the current pixel
- obstacleDR  in  1  obstacle/brick drawing request at the current pixel
- collision  out  1  one-cycle collision report pulse
- HitEdgeCode  out  4  [3]=left, [2]=top, [1]=right, [0]=bottom of smiley hit
- hitPixelCount  out  16  overlap pixel count of the last reported frame

Behaviour:
- Reset (async, resetN=0): state=IDLE_ST; collision=0; HitEdgeCode=0; hitPixelCount=0; all accumulators, snapshot registers and delay counter = 0.
- Per-pixel classification (combinational, registered into the accumulator the same cycle):
  - hit = smileyDR & obstacleDR.
  - offX = pixelX - topLeftX and offY = pixelY - topLeftY, 12-bit signed.
  - left = offX < EDGE_MARGIN; right = offX >= OBJECT_WIDTH_X - EDGE_MARGIN; top = offY < EDGE_MARGIN; bottom = offY >= OBJECT_HIGHT_Y - EDGE_MARGIN.
  - A corner pixel sets two bits. A centre pixel sets no edge bit but is still counted.
  - Negative offsets count as left/top (no wrap).
- Accumulator: on a hit, edgeAcc |= {left,top,right,bottom} and pixAcc += 1. pixAcc is 16-bit and saturates at 0xFFFF.
- States:
  - IDLE_ST: accumulation disabled; the partial first frame is discarded. startOfFrame -> COLLECT_ST with accumulators cleared.
  - COLLECT_ST: accumulate. On startOfFrame:
    - snapEdge=edgeAcc, snapCount=pixAcc; clear accumulators.
    - If pixAcc >= MIN_HIT_PIXELS and edgeAcc != 0: delayCnt=REPORT_DELAY-1, go to DELAY_ST.
    - Otherwise stay in COLLECT_ST with no report.
  - DELAY_ST: accumulation continues for the new frame; delayCnt decrements each cycle; at 0 -> PULSE_ST.
  - PULSE_ST: for exactly one cycle collision=1, HitEdgeCode=snapEdge, hitPixelCount=snapCount; then -> COLLECT_ST.
- Latency: the pulse is asserted exactly REPORT_DELAY cycles after the startOfFrame cycle (e.g. SOF at cycle N, pulse at N+4).
- HitEdgeCode and hitPixelCount are registered and hold their value until the next report. collision is high only in PULSE_ST.
- The pixel presented in the startOfFrame cycle is discarded and not counted in either frame.
- startOfFrame in DELAY_ST or PULSE_ST: the pending report is dropped and no pulse is issued for it. The SOF is then processed as in COLLECT_ST (snapshot, clear, possibly re-enter DELAY_ST).
- A hit with edgeAcc == 0 (centre-only overlap) never reports.
- resetN asserted mid-frame or mid-delay: immediate return to IDLE_ST; no pulse is issued; outputs return to 0.

Test Plan:
1. Reset, then SOF; 10 overlap pixels at offX=2, offY=30; SOF at cycle N -> collision=1 at N+4 for exactly 1 cycle, HitEdgeCode=4'b1000, hitPixelCount=10.
2. 3 overlap pixels at the top zone (offY=5), MIN_HIT_PIXELS=4, then SOF -> no pulse; HitEdgeCode keeps its previous value.
3. Overlap at the corner offX=60, offY=60 (×5) plus offX=30, offY=1 (×5), then SOF -> HitEdgeCode=4'b0111, hitPixelCount=10.
4. Overlaps in the first partial frame before any SOF are discarded; after the first SOF, one frame with 20 bottom hits (offY=55) -> HitEdgeCode=4'b0001, count=20.
5. 6 left hits, SOF, second SOF 2 cycles later -> first report dropped; the pulse relates to the second snapshot (0 hits -> no pulse).
6. resetN pulsed low in DELAY_ST -> collision never asserts; HitEdgeCode=0, state IDLE_ST.
